// File: rtl/uart_tx_arbiter_if.sv
// Wishbone master bus between uart_tx_arbiter and the Amber UART register block.
// Signal names are seen from the arbiter (master) side.
interface uart_tx_arbiter_if;
  logic [31:0] o_wb_adr;
  logic [3:0]  o_wb_sel;
  logic        o_wb_we;
  logic [31:0] o_wb_dat;
  logic [31:0] i_wb_dat;
  logic        o_wb_cyc;
  logic        o_wb_stb;
  logic        i_wb_ack;
  logic        i_wb_err;

  modport master (
    output o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
    input  i_wb_dat, i_wb_ack, i_wb_err
  );

  modport slave (
    input  o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
    output i_wb_dat, i_wb_ack, i_wb_err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter serialising four byte requesters onto one Amber UART over Wishbone.
// Define UART_ARB_TIMEOUT_EN to add a bus watchdog that aborts stalled cycles and pulses o_timeout.
module uart_tx_arbiter #(
  parameter logic [31:0] UART_BASE = 32'h1600_0000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [3:0]        i_req,
  input  logic [31:0]       i_req_data,
  output logic [3:0]        o_grant,
  output logic              o_busy,
  output logic              o_timeout,
  uart_tx_arbiter_if.master wb
);
  // Offsets match AMBER_UART_DR / AMBER_UART_FR in register_addresses.vh.
  localparam logic [31:0] AMBER_UART_DR = 32'h0000_0000;
  localparam logic [31:0] AMBER_UART_FR = 32'h0000_0018;

  typedef enum logic [1:0] {IDLE, POLL, GAP, WRITE} state_t;

  state_t      r_state, w_next;
  state_t      r_after_gap, w_after_gap;
  logic [1:0]  r_last, r_idx, w_win_idx, w_cand;
  logic [7:0]  r_byte;
  logic [3:0]  r_grant;
  logic        w_win_vld, w_latch, w_wr_done, w_abort;
  logic        w_stb, w_ack, w_err;

  assign w_ack = wb.i_wb_ack;
  assign w_err = wb.i_wb_err;
  assign w_stb = (r_state == POLL) || (r_state == WRITE);

  // Search starts one past the last granted requester.
  always_comb begin
    w_win_vld = 1'b0;
    w_win_idx = r_last;
    w_cand    = r_last;
    for (int unsigned k = 1; k <= 4; k++) begin
      w_cand = r_last + 2'(k);
      if (!w_win_vld && i_req[w_cand]) begin
        w_win_vld = 1'b1;
        w_win_idx = w_cand;
      end
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  logic [7:0] r_tmo_cnt;
  logic       r_timeout;

  // Abort lands on the 255th unanswered stb cycle, as the counter reaches 255.
  assign w_abort = w_stb && !w_ack && !w_err && (r_tmo_cnt == 8'd254);

  always_ff @(posedge i_clk) begin
    if (i_rst || !w_stb) begin
      r_tmo_cnt <= '0;
    end else if (!w_ack && !w_err) begin
      r_tmo_cnt <= r_tmo_cnt + 8'd1;
    end
    r_timeout <= i_rst ? 1'b0 : w_abort;
  end

  assign o_timeout = r_timeout;
`else
  assign w_abort   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Every bus response passes through GAP; r_after_gap records where to resume.
  always_comb begin
    w_next      = r_state;
    w_after_gap = r_after_gap;
    w_latch     = 1'b0;
    w_wr_done   = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_win_vld) begin
          w_next  = POLL;
          w_latch = 1'b1;
        end
      end
      POLL: begin
        if (w_err || w_abort) begin
          w_next      = GAP;
          w_after_gap = IDLE;
        end else if (w_ack) begin
          w_next      = GAP;
          w_after_gap = wb.i_wb_dat[5] ? POLL : WRITE;
        end
      end
      GAP: w_next = r_after_gap;
      WRITE: begin
        if (w_err || w_abort) begin
          w_next      = GAP;
          w_after_gap = IDLE;
        end else if (w_ack) begin
          w_next      = GAP;
          w_after_gap = IDLE;
          w_wr_done   = 1'b1;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= IDLE;
      r_after_gap <= IDLE;
      r_last      <= 2'd3;
      r_idx       <= '0;
      r_byte      <= '0;
      r_grant     <= '0;
    end else begin
      r_state     <= w_next;
      r_after_gap <= w_after_gap;
      r_grant     <= w_wr_done ? (4'b0001 << r_idx) : '0;
      if (w_wr_done) begin
        r_last <= r_idx;
      end
      if (w_latch) begin
        r_idx  <= w_win_idx;
        r_byte <= i_req_data[8*w_win_idx +: 8];
      end
    end
  end

  assign wb.o_wb_cyc = w_stb;
  assign wb.o_wb_stb = w_stb;
  assign wb.o_wb_we  = (r_state == WRITE);
  assign wb.o_wb_sel = w_stb ? 4'hf : '0;
  assign wb.o_wb_adr = (r_state == POLL)  ? UART_BASE + AMBER_UART_FR :
                       (r_state == WRITE) ? UART_BASE + AMBER_UART_DR : '0;
  assign wb.o_wb_dat = (r_state == WRITE) ? {24'h0, r_byte} : '0;
  assign o_busy      = (r_state != IDLE);
  assign o_grant     = r_grant;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: Wishbone UART slave model plus grant/DR-write checks.
module tb_uart_tx_arbiter;
  localparam logic [31:0] BASE = 32'h1600_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  grant;
  logic        busy, tmo;

  uart_tx_arbiter_if wb();

  uart_tx_arbiter #(.UART_BASE(BASE)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_req      (req),
    .i_req_data (req_data),
    .o_grant    (grant),
    .o_busy     (busy),
    .o_timeout  (tmo),
    .wb         (wb)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc_n = 0;

  logic [3:0]  exp_g[$];
  logic [31:0] exp_d[$];
  logic [31:0] fr_q[$];
  int          poll_t[$];
  int          grant_t[$];
  bit          ack_en = 1'b1;
  bit          wr_ack_en = 1'b1;
  int          err_writes = 0;

  always @(posedge clk) cyc_n++;

  // UART slave: single-cycle responses decided at negedge, sampled by the DUT at the next posedge.
  always @(negedge clk) begin
    bit a, e;
    logic [3:0]  eg;
    logic [31:0] ed;
    a = 1'b0;
    e = 1'b0;
    if (wb.o_wb_stb === 1'b1) begin
      if (!wb.o_wb_we) begin
        a = ack_en;
      end else if (err_writes > 0) begin
        e = 1'b1;
        err_writes--;
      end else begin
        a = ack_en && wr_ack_en;
      end
    end
    wb.i_wb_ack = a;
    wb.i_wb_err = e;
    wb.i_wb_dat = '0;
    if (a && !wb.o_wb_we) begin
      wb.i_wb_dat = (fr_q.size() > 0) ? fr_q.pop_front() : 32'h90;
      poll_t.push_back(cyc_n);
    end

    n_cmp++;
    if (wb.o_wb_cyc !== wb.o_wb_stb) begin
      n_err++;
      $display("FAIL cyc_eq_stb: cyc=%b stb=%b", wb.o_wb_cyc, wb.o_wb_stb);
    end
    if (wb.o_wb_stb === 1'b1 && wb.o_wb_we === 1'b0) begin
      n_cmp++;
      if (wb.o_wb_adr !== BASE + 32'h18 || wb.o_wb_sel !== 4'hf || wb.o_wb_dat !== 32'h0) begin
        n_err++;
        $display("FAIL poll_bus: adr=%h sel=%h dat=%h want adr=%h sel=f dat=0",
                 wb.o_wb_adr, wb.o_wb_sel, wb.o_wb_dat, BASE + 32'h18);
      end
    end
    if (a && wb.o_wb_we === 1'b1) begin
      n_cmp++;
      ed = (exp_d.size() > 0) ? exp_d.pop_front() : 32'hxxxx_xxxx;
      if (wb.o_wb_dat !== ed || wb.o_wb_adr !== BASE || wb.o_wb_sel !== 4'hf) begin
        n_err++;
        $display("FAIL dr_write: adr=%h sel=%h dat=%h want adr=%h sel=f dat=%h",
                 wb.o_wb_adr, wb.o_wb_sel, wb.o_wb_dat, BASE, ed);
      end
    end
    if (grant !== 4'b0) begin
      n_cmp++;
      grant_t.push_back(cyc_n);
      eg = (exp_g.size() > 0) ? exp_g.pop_front() : 4'bxxxx;
      if (grant !== eg) begin
        n_err++;
        $display("FAIL grant: got %b want %b", grant, eg);
      end
    end
  end

  task automatic run_grants(input int n, input int budget, input bit clear_each, output bit ok);
    int got;
    got = 0;
    ok  = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (grant !== 4'b0) begin
        got++;
        if (clear_each) req = req & ~grant;
        if (got == n) begin
          req = '0;
          ok  = 1'b1;
        end
      end
    end
  endtask

  task automatic settle_idle(input string name);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || exp_g.size() != 0 || exp_d.size() != 0) begin
      n_err++;
      $display("FAIL %s_idle: busy=%b pending_grants=%0d pending_writes=%0d want 0/0/0",
               name, busy, exp_g.size(), exp_d.size());
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (grant !== 4'b0 || busy !== 1'b0 || tmo !== 1'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: grant=%b busy=%b tmo=%b want 0/0/0", grant, busy, tmo);
    end
    n_cmp++;
    if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0 || wb.o_wb_we !== 1'b0 || wb.o_wb_sel !== 4'h0) begin
      n_err++;
      $display("FAIL reset_bus_ctl: cyc=%b stb=%b we=%b sel=%h want 0", wb.o_wb_cyc, wb.o_wb_stb,
               wb.o_wb_we, wb.o_wb_sel);
    end
    n_cmp++;
    if (wb.o_wb_adr !== 32'h0 || wb.o_wb_dat !== 32'h0) begin
      n_err++;
      $display("FAIL reset_bus_data: adr=%h dat=%h want 0/0", wb.o_wb_adr, wb.o_wb_dat);
    end
    rst = 1'b0;
  endtask

  task automatic test_single();
    bit ok;
    poll_t.delete();
    fr_q.push_back(32'h90);
    req_data = 32'h0000_0041;
    exp_g.push_back(4'b0001);
    exp_d.push_back(32'h41);
    req = 4'b0001;
    run_grants(1, 50, 1'b1, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL single_done: got %b want 1", ok);
    end
    repeat (8) @(negedge clk);
    settle_idle("single");
    n_cmp++;
    if (poll_t.size() != 1) begin
      n_err++;
      $display("FAIL single_polls: got %0d want 1", poll_t.size());
    end
  endtask

  task automatic test_round_robin();
    bit ok;
    logic [3:0] order [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    grant_t.delete();
    req_data = 32'h1312_1110;
    foreach (order[i]) begin
      exp_g.push_back(order[i]);
      case (order[i])
        4'b0001: exp_d.push_back(32'h10);
        4'b0010: exp_d.push_back(32'h11);
        4'b0100: exp_d.push_back(32'h12);
        default: exp_d.push_back(32'h13);
      endcase
    end
    req = 4'b1111;
    run_grants(5, 100, 1'b0, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL rr_done: got %b want 1", ok);
    end
    settle_idle("rr");
    for (int i = 0; i + 1 < grant_t.size(); i++) begin
      n_cmp++;
      if (grant_t[i+1] - grant_t[i] != 5) begin
        n_err++;
        $display("FAIL rr_spacing: got %0d want 5", grant_t[i+1] - grant_t[i]);
      end
    end
  endtask

  task automatic test_fifo_full();
    bit ok;
    poll_t.delete();
    fr_q = '{32'hA0, 32'hA0, 32'hA0, 32'h90};
    req_data = 32'h0000_5500;
    exp_g.push_back(4'b0010);
    exp_d.push_back(32'h55);
    req = 4'b0010;
    run_grants(1, 60, 1'b1, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL full_done: got %b want 1", ok);
    end
    settle_idle("full");
    n_cmp++;
    if (poll_t.size() != 4) begin
      n_err++;
      $display("FAIL full_polls: got %0d want 4", poll_t.size());
    end
    for (int i = 0; i + 1 < poll_t.size(); i++) begin
      n_cmp++;
      if (poll_t[i+1] - poll_t[i] != 2) begin
        n_err++;
        $display("FAIL full_poll_gap: got %0d want 2", poll_t[i+1] - poll_t[i]);
      end
    end
  endtask

  task automatic test_write_err();
    bit ok;
    poll_t.delete();
    // Pointer last granted 1: requester 2 wins; an erroneous update would let 0 win the retry.
    req_data = 32'h0077_0066;
    err_writes = 1;
    exp_g.push_back(4'b0100);
    exp_g.push_back(4'b0001);
    exp_d.push_back(32'h77);
    exp_d.push_back(32'h66);
    req = 4'b0101;
    run_grants(2, 80, 1'b1, ok);
    n_cmp++;
    if (ok !== 1'b1) begin
      n_err++;
      $display("FAIL err_done: got %b want 1", ok);
    end
    settle_idle("err");
    n_cmp++;
    if (poll_t.size() != 3 || err_writes != 0) begin
      n_err++;
      $display("FAIL err_polls: polls=%0d errs_left=%0d want 3/0", poll_t.size(), err_writes);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    bit seen;
    seen = 1'b0;
    wr_ack_en = 1'b0;
    req_data = 32'h9900_0000;
    req = 4'b1000;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (wb.o_wb_stb === 1'b1 && wb.o_wb_we === 1'b1) seen = 1'b1;
    end
    n_cmp++;
    if (seen !== 1'b1) begin
      n_err++;
      $display("FAIL rstmid_write_seen: got %b want 1", seen);
    end
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    n_cmp++;
    if (wb.o_wb_cyc !== 1'b0 || wb.o_wb_stb !== 1'b0 || grant !== 4'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL rstmid_drop: cyc=%b stb=%b grant=%b busy=%b want 0", wb.o_wb_cyc,
               wb.o_wb_stb, grant, busy);
    end
    rst = 1'b0;
    wr_ack_en = 1'b1;
    poll_t.delete();
    req_data = 32'h003C_0000;
    exp_g.push_back(4'b0100);
    exp_d.push_back(32'h3C);
    req = 4'b0100;
    run_grants(1, 50, 1'b1, ok);
    n_cmp++;
    if (ok !== 1'b1 || poll_t.size() != 1) begin
      n_err++;
      $display("FAIL rstmid_serve: done=%b polls=%0d want 1/1", ok, poll_t.size());
    end
    settle_idle("rstmid");
  endtask

  task automatic test_timeout();
    int  nstb;
    bit  seen;
    nstb = 0;
    seen = 1'b0;
    ack_en = 1'b0;
    req_data = 32'h0000_0001;
    req = 4'b0001;
`ifdef UART_ARB_TIMEOUT_EN
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (wb.o_wb_stb === 1'b1) nstb++;
      if (tmo === 1'b1) seen = 1'b1;
    end
    req = '0;
    n_cmp++;
    if (seen !== 1'b1 || nstb != 255) begin
      n_err++;
      $display("FAIL tmo_pulse: seen=%b stb_cycles=%0d want 1/255", seen, nstb);
    end
    @(negedge clk);
    n_cmp++;
    if (tmo !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_idle: tmo=%b busy=%b want 0/0", tmo, busy);
    end
`else
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (wb.o_wb_stb === 1'b1) nstb++;
      if (tmo !== 1'b0) seen = 1'b1;
    end
    n_cmp++;
    if (wb.o_wb_stb !== 1'b1 || seen !== 1'b0 || nstb < 295) begin
      n_err++;
      $display("FAIL tmo_hold: stb=%b tmo_seen=%b stb_cycles=%0d want 1/0/>=295", wb.o_wb_stb,
               seen, nstb);
    end
`endif
    ack_en = 1'b1;
    do_reset();
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || wb.o_wb_stb !== 1'b0) begin
      n_err++;
      $display("FAIL tmo_cleanup: busy=%b stb=%b want 0/0", busy, wb.o_wb_stb);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_fifo_full();
    test_write_err();
    test_reset_mid();
    test_timeout();
    n_cmp++;
    if (exp_g.size() != 0 || exp_d.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: grants=%0d writes=%0d want 0/0", exp_g.size(), exp_d.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
